fetch_redirect_unit: RTL and testbench

- Front-end PC sequencer and consumer of the execute-stage branch redirect: takes `Request_Alt_PC` / `alt_addr` and steers instruction fetch.
- Owns the fetch PC and issues requests to instruction memory.
- Tracks in-flight requests, squashes wrong-path responses after a redirect, and delivers in-order `{instr, PC}` to decode with backpressure.

---
 rtl/fetch_redirect_unit_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_redirect_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch redirect unit: FSM encodings, reset PC, response layout.
// Latency: none (declarations only).
// Backpressure: n/a.
package fetch_redirect_unit_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

    // Kept as plain logic constants so older blocks can compare against them directly.
    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // One delivered fetch: instruction word plus the PC it was fetched from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } resp_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with single-cycle flush; head is visible combinationally.
// Latency: a pushed entry is at the head the cycle after the push.
// Backpressure: push ignored when full (unless popping), pop ignored when empty; flush wins.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push_vld && (!full || pop_rdy) && !flush;
    assign do_pop   = pop_rdy && !empty && !flush;
    assign head_dat = mem[rd_ptr];

    // Storage is not reset; the count alone says which slots are meaningful.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC sequencer: issues imem requests, squashes wrong-path responses after a redirect.
// Latency: response visible at Instr1 the cycle after Rvalid; Flush_Ack one cycle after redirect.
// Backpressure: Stall_IN holds Instr1; issue is credit-limited to DEPTH (in-flight + buffered).
// Optional: REDIRECT_STATS_EN adds saturating redirect/drop/deliver counters and a redirect log.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Request_Alt_PC,
    input  logic [31:0] alt_addr,
    input  logic        Stall_IN,
    output logic        Imem_Req_OUT,
    output logic [31:0] Imem_Addr_OUT,
    input  logic        Imem_Gnt_IN,
    input  logic        Imem_Rvalid_IN,
    input  logic [31:0] Imem_Rdata_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic        Instr1_Valid_OUT,
    output logic        Flush_Ack_OUT
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [1:0]    state;
    logic [31:0]   pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] resp_count;
    logic [CW-1:0] inflight_after;
    logic [CW:0]   occupancy;
    logic [31:0]   tag_head_dat;
    logic          tag_empty;
    logic          resp_empty;
    resp_t         resp_push_dat;
    resp_t         resp_head_dat;
    logic          grant;
    logic          rsp_take;
    logic          keep_rsp;
    logic          deliver;

    assign occupancy      = {1'b0, tag_count} + {1'b0, resp_count};
    assign Imem_Req_OUT   = (state != ST_START) && (occupancy < DEPTH_W);
    assign Imem_Addr_OUT  = pc;
    assign grant          = Imem_Req_OUT && Imem_Gnt_IN;
    // Rvalid with nothing outstanding is a protocol error and is simply ignored.
    assign rsp_take       = Imem_Rvalid_IN && !tag_empty;
    // A redirect this cycle makes the arriving response wrong-path as well.
    assign keep_rsp       = rsp_take && (drop_cnt == '0) && !Request_Alt_PC;
    assign deliver        = !resp_empty && !Stall_IN && !Request_Alt_PC;
    // Entries still owed by memory once this cycle's grant and response are accounted for.
    assign inflight_after = tag_count + CW'(grant) - CW'(rsp_take);

    assign resp_push_dat.instr = Imem_Rdata_IN;
    assign resp_push_dat.pc    = tag_head_dat;

    assign Instr1_Valid_OUT = !resp_empty;
    assign Instr1_OUT       = resp_empty ? '0 : resp_head_dat.instr;
    assign Instr1_PC_OUT    = resp_empty ? '0 : resp_head_dat.pc;

    // Tag queue: PCs of granted requests, in the order memory will answer them.
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .CLK      (CLK),
        .RESET    (RESET),
        .flush    (1'b0),
        .push_vld (grant),
        .push_dat (pc),
        .pop_rdy  (rsp_take),
        .head_dat (tag_head_dat),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    // Response queue: correct-path {instr, pc} waiting for decode; cleared on redirect.
    fetch_fifo #(.WIDTH($bits(resp_t)), .DEPTH(DEPTH)) u_resp_q (
        .CLK      (CLK),
        .RESET    (RESET),
        .flush    (Request_Alt_PC),
        .push_vld (keep_rsp),
        .push_dat (resp_push_dat),
        .pop_rdy  (deliver),
        .head_dat (resp_head_dat),
        .empty    (resp_empty),
        .count    (resp_count)
    );

    // PC, drop counter and FSM; a redirect overrides every same-cycle update.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= ST_START;
            pc            <= RESET_PC;
            drop_cnt      <= '0;
            Flush_Ack_OUT <= 1'b0;
        end else begin
            Flush_Ack_OUT <= Request_Alt_PC;
            if (Request_Alt_PC) begin
                pc       <= alt_addr;
                drop_cnt <= inflight_after;
                state    <= (inflight_after != '0) ? ST_DRAIN : ST_RUN;
            end else begin
                if (grant) pc <= pc + 32'd4;
                if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
                case (state)
                    ST_START: state <= ST_RUN;
                    ST_RUN:   state <= ST_RUN;
                    ST_DRAIN: if (rsp_take && (drop_cnt == CW'(1))) state <= ST_RUN;
                    default:  state <= ST_RUN;
                endcase
            end
        end
    end

`ifdef REDIRECT_STATS_EN
    logic [31:0] redirect_count;
    logic [31:0] dropped_count;
    logic [31:0] delivered_count;
    logic        discard;

    assign discard = rsp_take && ((drop_cnt != '0) || Request_Alt_PC);

    // Saturating event counters plus a log line per redirect.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            redirect_count  <= '0;
            dropped_count   <= '0;
            delivered_count <= '0;
        end else begin
            if (Request_Alt_PC && (redirect_count != '1))  redirect_count  <= redirect_count + 1'b1;
            if (discard && (dropped_count != '1))          dropped_count   <= dropped_count + 1'b1;
            if (deliver && (delivered_count != '1))        delivered_count <= delivered_count + 1'b1;
            if (Request_Alt_PC)
                $display("FETCH: redirect to %h, squashing %0d in flight", alt_addr, inflight_after);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;

    logic        CLK;
    logic        RESET;
    logic        Request_Alt_PC;
    logic [31:0] alt_addr;
    logic        Stall_IN;
    logic        Imem_Req_OUT;
    logic [31:0] Imem_Addr_OUT;
    logic        Imem_Gnt_IN;
    logic        Imem_Rvalid_IN;
    logic [31:0] Imem_Rdata_IN;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr1_PC_OUT;
    logic        Instr1_Valid_OUT;
    logic        Flush_Ack_OUT;

    fetch_redirect_unit dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Request_Alt_PC   (Request_Alt_PC),
        .alt_addr         (alt_addr),
        .Stall_IN         (Stall_IN),
        .Imem_Req_OUT     (Imem_Req_OUT),
        .Imem_Addr_OUT    (Imem_Addr_OUT),
        .Imem_Gnt_IN      (Imem_Gnt_IN),
        .Imem_Rvalid_IN   (Imem_Rvalid_IN),
        .Imem_Rdata_IN    (Imem_Rdata_IN),
        .Instr1_OUT       (Instr1_OUT),
        .Instr1_PC_OUT    (Instr1_PC_OUT),
        .Instr1_Valid_OUT (Instr1_Valid_OUT),
        .Flush_Ack_OUT    (Flush_Ack_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: grants when gnt_en, answers in order lat edges after the grant.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        gnt_en;
    int          lat;
    int          edge_no;
    pend_t       pend[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] issue_log[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5AA5A5;
    endfunction

    // One clock: drive memory inputs, log issue/delivery, advance model, return at negedge.
    task automatic tick();
        logic        take;
        logic        rsp;
        logic [31:0] taddr;
        Imem_Gnt_IN    = gnt_en;
        rsp            = (pend.size() > 0) && (pend[0].due <= edge_no + 1);
        Imem_Rvalid_IN = rsp;
        Imem_Rdata_IN  = rsp ? memf(pend[0].addr) : 32'h0;
        #1;
        take  = Imem_Req_OUT && gnt_en;
        taddr = Imem_Addr_OUT;
        if (Instr1_Valid_OUT && !Stall_IN && !Request_Alt_PC) begin
            dlv_pc.push_back(Instr1_PC_OUT);
            chk("instr_data", Instr1_OUT, memf(Instr1_PC_OUT));
        end
        @(posedge CLK);
        edge_no++;
        if (rsp) pend.delete(0);
        if (take) begin
            pend.push_back(pend_t'{taddr, edge_no + lat});
            issue_log.push_back(taddr);
        end
        #1 Request_Alt_PC = 1'b0;
        @(negedge CLK);
    endtask

    task automatic clear_all();
        Request_Alt_PC = 1'b0;
        alt_addr       = 32'h0;
        Stall_IN       = 1'b0;
        Imem_Gnt_IN    = 1'b0;
        Imem_Rvalid_IN = 1'b0;
        Imem_Rdata_IN  = 32'h0;
        gnt_en         = 1'b0;
        lat            = 2;
        pend.delete();
        dlv_pc.delete();
        issue_log.delete();
    endtask

    // Reset held over two edges, released at a negedge; returns in the START cycle.
    task automatic do_reset();
        RESET = 1'b0;
        clear_all();
        repeat (2) @(negedge CLK);
        RESET   = 1'b1;
        edge_no = 0;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        while (dlv_pc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_timeout"}, 32'(dlv_pc.size() >= n), 32'd1);
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < dlv_pc.size()) chk(tag, dlv_pc[i], base + 32'(4 * i));
            else                   chk({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        // Reset state and straight-line streaming.
        RESET = 1'b0;
        clear_all();
        @(negedge CLK);
        chk("rst_req",   {31'd0, Imem_Req_OUT},     32'd0);
        chk("rst_vld",   {31'd0, Instr1_Valid_OUT}, 32'd0);
        chk("rst_instr", Instr1_OUT,                32'd0);
        chk("rst_pc",    Instr1_PC_OUT,             32'd0);
        chk("rst_ack",   {31'd0, Flush_Ack_OUT},    32'd0);
        @(negedge CLK);
        RESET   = 1'b1;
        edge_no = 0;
        chk("start_req", {31'd0, Imem_Req_OUT}, 32'd0);
        gnt_en = 1'b1;
        lat    = 2;
        tick();
        chk("run_req",  {31'd0, Imem_Req_OUT}, 32'd1);
        chk("run_addr", Imem_Addr_OUT,         32'hBFC00000);
        repeat (11) tick();
        chk("stream_issued", 32'(issue_log.size()), 32'd11);
        for (int i = 0; i < 11 && i < issue_log.size(); i++)
            chk("stream_issue_addr", issue_log[i], 32'hBFC00000 + 32'(4 * i));
        chk("stream_count", 32'(dlv_pc.size()), 32'd8);
        chk_seq("stream_pc", 32'hBFC00000, 8);

        // Redirect with three requests in flight.
        do_reset();
        gnt_en = 1'b1;
        lat    = 10;
        repeat (4) tick();
        gnt_en         = 1'b0;
        Request_Alt_PC = 1'b1;
        alt_addr       = 32'h00400100;
        tick();
        chk("redir3_ack",  {31'd0, Flush_Ack_OUT},    32'd1);
        chk("redir3_addr", Imem_Addr_OUT,             32'h00400100);
        chk("redir3_vld",  {31'd0, Instr1_Valid_OUT}, 32'd0);
        dlv_pc.delete();
        gnt_en = 1'b1;
        lat    = 2;
        tick();
        chk("redir3_ack_pulse", {31'd0, Flush_Ack_OUT}, 32'd0);
        run_until(3, 40, "redir3");
        chk_seq("redir3_pc", 32'h00400100, 3);

        // Redirect in the same cycle as a grant and a response, two in flight.
        do_reset();
        gnt_en = 1'b1;
        lat    = 2;
        repeat (5) tick();
        Request_Alt_PC = 1'b1;
        alt_addr       = 32'h00000500;
        tick();
        chk("same_addr", Imem_Addr_OUT,             32'h00000500);
        chk("same_ack",  {31'd0, Flush_Ack_OUT},    32'd1);
        chk("same_vld",  {31'd0, Instr1_Valid_OUT}, 32'd0);
        chk("same_drop", 32'(dut.drop_cnt),         32'd2);
        dlv_pc.delete();
        run_until(3, 40, "same");
        chk_seq("same_pc", 32'h00000500, 3);

        // Stall for ten-plus cycles with memory always ready.
        do_reset();
        Stall_IN = 1'b1;
        gnt_en   = 1'b1;
        lat      = 2;
        repeat (12) begin
            tick();
            if (Instr1_Valid_OUT) begin
                chk("stall_hold_pc",    Instr1_PC_OUT, 32'hBFC00000);
                chk("stall_hold_instr", Instr1_OUT,    memf(32'hBFC00000));
            end
        end
        chk("stall_req",    {31'd0, Imem_Req_OUT}, 32'd0);
        chk("stall_issued", 32'(issue_log.size()), 32'd4);
        Stall_IN = 1'b0;
        run_until(8, 60, "stall");
        chk_seq("stall_pc", 32'hBFC00000, 8);
        if (issue_log.size() > 4) chk("stall_resume_addr", issue_log[4], 32'hBFC00010);
        else                      chk("stall_resume_missing", 32'd0, 32'd1);

        // Back-to-back redirects: only the second target survives.
        do_reset();
        gnt_en = 1'b1;
        lat    = 2;
        repeat (4) tick();
        Request_Alt_PC = 1'b1;
        alt_addr       = 32'h00000100;
        tick();
        Request_Alt_PC = 1'b1;
        alt_addr       = 32'h00000200;
        tick();
        dlv_pc.delete();
        chk("b2b_addr", Imem_Addr_OUT,          32'h00000200);
        chk("b2b_ack",  {31'd0, Flush_Ack_OUT}, 32'd1);
        run_until(3, 40, "b2b");
        chk_seq("b2b_pc", 32'h00000200, 3);

        // Reset asserted while draining.
        do_reset();
        gnt_en = 1'b1;
        lat    = 10;
        repeat (4) tick();
        gnt_en         = 1'b0;
        Request_Alt_PC = 1'b1;
        alt_addr       = 32'h00400100;
        tick();
        chk("drain_state", 32'(dut.state), 32'd2);
        RESET = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, Imem_Req_OUT},     32'd0);
        chk("mid_rst_vld",   {31'd0, Instr1_Valid_OUT}, 32'd0);
        chk("mid_rst_instr", Instr1_OUT,                32'd0);
        chk("mid_rst_pc",    Instr1_PC_OUT,             32'd0);
        chk("mid_rst_ack",   {31'd0, Flush_Ack_OUT},    32'd0);
        clear_all();
        @(negedge CLK);
        RESET   = 1'b1;
        edge_no = 0;
        chk("mid_rst_start_req", {31'd0, Imem_Req_OUT}, 32'd0);
        gnt_en = 1'b1;
        lat    = 2;
        tick();
        chk("mid_rst_resume_req",  {31'd0, Imem_Req_OUT}, 32'd1);
        chk("mid_rst_resume_addr", Imem_Addr_OUT,         32'hBFC00000);
        run_until(2, 20, "mid_rst");
        chk_seq("mid_rst_pc", 32'hBFC00000, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=%0d exp=finished", n_total);
        $fatal(1, "simulation did not finish");
    end

endmodule
